// File: rtl/accumulator_array_p.sv
// -----------------------------------------------------------------------------
// accumulator_array_p
//
// Purpose
//   Sits between the systolic-array partial-sum outputs and the activation
//   writer. N_COL independent column engines each accumulate signed psums over
//   all input channels of a tile into a local buffer that holds one value per
//   ofmap element. Once the last channel of a tile has arrived, the engine
//   requantises every buffered sum (rounding arithmetic right shift, then
//   saturation to OUT_W) and drains them through a valid/ready output that
//   honours backpressure.
//
// Ports
//   clk            in   1              clock, rising edge
//   rst_n          in   1              asynchronous active-low reset
//   psum_i         in   N_COL*PSUM_W   column c psum at [c*PSUM_W +: PSUM_W], signed
//   pvalid_i       in   N_COL          per-column psum valid
//   pready_o       out  N_COL          per-column psum ready
//   ofmap_size_i   in   log2(MAX_OFMAP) ofmap elements minus 1
//   ifmap_ch_i     in   log2(MAX_CH)   input channels minus 1
//   shift_i        in   log2(ACC_W)    requantisation right shift
//   conv_valid_o   out  N_COL          per-column result valid
//   conv_ready_i   in   N_COL          per-column result ready
//   conv_result_o  out  N_COL*OUT_W    column c result at [c*OUT_W +: OUT_W], signed
//
// Build option
//   ACC_RELU_EN    when defined, negative requantised results are clamped to 0
//                  after saturation. Undefined (default): signed saturation only.
// -----------------------------------------------------------------------------
module accumulator_array_p #(
    parameter int N_COL     = 128,
    parameter int PSUM_W    = 8,
    parameter int ACC_W     = 16,
    parameter int OUT_W     = 8,
    parameter int MAX_OFMAP = 64,
    parameter int MAX_CH    = 256
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_COL*PSUM_W-1:0]       psum_i,
    input  logic [N_COL-1:0]              pvalid_i,
    output logic [N_COL-1:0]              pready_o,
    input  logic [$clog2(MAX_OFMAP)-1:0]  ofmap_size_i,
    input  logic [$clog2(MAX_CH)-1:0]     ifmap_ch_i,
    input  logic [$clog2(ACC_W)-1:0]      shift_i,
    output logic [N_COL-1:0]              conv_valid_o,
    input  logic [N_COL-1:0]              conv_ready_i,
    output logic [N_COL*OUT_W-1:0]        conv_result_o
);

    localparam int IDX_W = $clog2(MAX_OFMAP);
    localparam int CH_W  = $clog2(MAX_CH);
    localparam int SH_W  = $clog2(ACC_W);

    // Saturation bounds expressed at the ACC_W+1 width of the rounded value.
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((1 << (OUT_W-1)) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-(1 << (OUT_W-1)));

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_e;

    // A channel sum of MAX_CH full-scale psums must fit the accumulator.
    if (ACC_W < PSUM_W + $clog2(MAX_CH)) begin : g_acc_w_check
        $error("accumulator_array_p: ACC_W must be >= PSUM_W + clog2(MAX_CH)");
    end

    // Rounding arithmetic right shift (round half up). One extra bit of
    // headroom keeps the rounding bias from overflowing a full-scale sum.
    function automatic logic signed [ACC_W:0] round_shift(
        input logic signed [ACC_W-1:0] x,
        input logic        [SH_W-1:0]  sh
    );
        logic signed [ACC_W:0] ext;
        logic signed [ACC_W:0] bias;
        ext = (ACC_W+1)'(x);
        if (sh != '0) begin
            bias = {{ACC_W{1'b0}}, 1'b1} << (sh - SH_W'(1));
            return (ext + bias) >>> sh;
        end
        return ext;
    endfunction

    // Clip the rounded value into the signed OUT_W range (optionally to >= 0).
    function automatic logic signed [OUT_W-1:0] saturate(
        input logic signed [ACC_W:0] r_in
    );
        logic signed [ACC_W:0] r;
        r = r_in;
        if (r > SAT_MAX) begin
            r = SAT_MAX;
        end else if (r < SAT_MIN) begin
            r = SAT_MIN;
        end
`ifdef ACC_RELU_EN
        if (r[ACC_W]) begin
            r = '0;
        end
`endif
        return r[OUT_W-1:0];
    endfunction

    function automatic logic signed [OUT_W-1:0] requant(
        input logic signed [ACC_W-1:0] x,
        input logic        [SH_W-1:0]  sh
    );
        return saturate(round_shift(x, sh));
    endfunction

    for (genvar c = 0; c < N_COL; c++) begin : g_col
        state_e                   state_q, state_d;
        logic [IDX_W-1:0]         idx_q, idx_d;
        logic [CH_W-1:0]          ch_q, ch_d;
        logic [IDX_W-1:0]         oidx_q, oidx_d;
        logic [IDX_W-1:0]         size_q, size_d;
        logic [CH_W-1:0]          chn_q, chn_d;
        logic [SH_W-1:0]          shift_q, shift_d;
        logic                     vld_q, vld_d;
        logic signed [OUT_W-1:0]  res_q, res_d;
        logic signed [ACC_W-1:0]  mem_q [MAX_OFMAP];

        logic signed [PSUM_W-1:0] psum;
        logic signed [ACC_W-1:0]  acc_sum;
        logic                     beat;
        logic                     first;
        logic [IDX_W-1:0]         eff_size;
        logic [CH_W-1:0]          eff_chn;

        assign psum  = psum_i[c*PSUM_W +: PSUM_W];
        assign beat  = (state_q == ACCUM) && pvalid_i[c];
        assign first = (idx_q == '0) && (ch_q == '0);

        // The first beat of a tile must already use the incoming config,
        // because it is only latched at the end of that same cycle.
        assign eff_size = first ? ofmap_size_i : size_q;
        assign eff_chn  = first ? ifmap_ch_i   : chn_q;

        // Channel 0 overwrites the slot, so no buffer clear is needed.
        assign acc_sum = (ch_q == '0) ? ACC_W'(psum)
                                      : mem_q[idx_q] + ACC_W'(psum);

        always_comb begin
            state_d = state_q;
            idx_d   = idx_q;
            ch_d    = ch_q;
            oidx_d  = oidx_q;
            size_d  = size_q;
            chn_d   = chn_q;
            shift_d = shift_q;
            vld_d   = vld_q;
            res_d   = res_q;
            case (state_q)
                ACCUM: begin
                    if (beat) begin
                        if (first) begin
                            size_d  = ofmap_size_i;
                            chn_d   = ifmap_ch_i;
                            shift_d = shift_i;
                        end
                        if (idx_q == eff_size) begin
                            idx_d = '0;
                            if (ch_q == eff_chn) begin
                                ch_d    = '0;
                                oidx_d  = '0;
                                state_d = DRAIN;
                            end else begin
                                ch_d = ch_q + CH_W'(1);
                            end
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (!vld_q) begin
                        // First cycle of the drain: the last write has landed.
                        res_d = requant(mem_q[oidx_q], shift_q);
                        vld_d = 1'b1;
                    end else if (conv_ready_i[c]) begin
                        if (oidx_q == size_q) begin
                            vld_d   = 1'b0;
                            state_d = ACCUM;
                        end else begin
                            // Prefetch the next element so accepted results stream without a bubble.
                            oidx_d = oidx_q + IDX_W'(1);
                            res_d  = requant(mem_q[oidx_q + IDX_W'(1)], shift_q);
                        end
                    end
                end
                default: state_d = ACCUM;
            endcase
        end

        // ---- control / result register stage ----
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ACCUM;
                idx_q   <= '0;
                ch_q    <= '0;
                oidx_q  <= '0;
                size_q  <= '0;
                chn_q   <= '0;
                shift_q <= '0;
                vld_q   <= 1'b0;
                res_q   <= '0;
            end else begin
                state_q <= state_d;
                idx_q   <= idx_d;
                ch_q    <= ch_d;
                oidx_q  <= oidx_d;
                size_q  <= size_d;
                chn_q   <= chn_d;
                shift_q <= shift_d;
                vld_q   <= vld_d;
                res_q   <= res_d;
            end
        end

        // ---- accumulator buffer write stage ----
        always_ff @(posedge clk) begin
            if (beat) begin
                mem_q[idx_q] <= acc_sum;
            end
        end

        assign pready_o[c]                     = (state_q == ACCUM);
        assign conv_valid_o[c]                 = vld_q;
        assign conv_result_o[c*OUT_W +: OUT_W] = res_q;
    end

endmodule
